// File: rtl/free_list_ckpt.sv
// Multi-lane physical-register free list: circular queue of free preg tags with
// rename-side allocate lanes, commit-side release lanes and branch checkpoints.
module free_list_ckpt #(
  parameter int PREG_BITS  = 6,
  parameter int DEPTH_BITS = 5,
  parameter int NUM_ARCH   = 32,
  parameter int NALLOC     = 2,
  parameter int NFREE      = 2,
  parameter int NCKPT      = 4,
  localparam int CKPT_BITS = $clog2(NCKPT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NALLOC-1:0]                alloc_req,
  output logic                             alloc_ready,
  output logic [NALLOC-1:0][PREG_BITS-1:0] alloc_preg,
  input  logic [NFREE-1:0]                 free_valid,
  input  logic [NFREE-1:0][PREG_BITS-1:0]  free_preg,
  input  logic                             ckpt_save,
  input  logic [CKPT_BITS-1:0]             ckpt_save_id,
  input  logic                             ckpt_restore,
  input  logic [CKPT_BITS-1:0]             ckpt_restore_id,
  input  logic                             flush,
  output logic [DEPTH_BITS:0]              free_count,
  output logic                             overflow_err
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  typedef logic [DEPTH_BITS:0] ptr_t;

  logic [PREG_BITS-1:0] mem [DEPTH];
  ptr_t                 slot [NCKPT];
  ptr_t                 rd_ptr, wr_ptr;
  ptr_t                 rd_ptr_next, wr_ptr_next, rd_ptr_d;
  ptr_t                 alloc_cnt, free_cnt, taken, count_after_alloc;
  ptr_t                 alloc_idx;
  ptr_t                 free_idx [NFREE];
  logic [DEPTH_BITS+1:0] count_total;
  logic                 free_ovf;
  logic                 save_en;

  assign free_count  = wr_ptr - rd_ptr;
  assign alloc_ready = (free_count >= ptr_t'(NALLOC)) && !flush && !ckpt_restore;

  // Lane k reads the entry offset by the number of requesting lanes below it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    alloc_cnt  = '0;
    alloc_idx  = '0;
    alloc_preg = 'x;
    for (int k = 0; k < NALLOC; k++) begin
      if (alloc_req[k]) begin
        alloc_idx     = rd_ptr + alloc_cnt;
        alloc_preg[k] = mem[alloc_idx[DEPTH_BITS-1:0]];
        alloc_cnt     = alloc_cnt + ptr_t'(1);
      end
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int j = 0; j < NFREE; j++) begin
      free_idx[j] = wr_ptr + free_cnt;
      if (free_valid[j]) free_cnt = free_cnt + ptr_t'(1);
    end
  end

  // Frees that would push the pool past DEPTH are dropped and flagged.
  always_comb begin
    taken             = alloc_ready ? alloc_cnt : '0;
    count_after_alloc = free_count - taken;
    count_total       = {1'b0, count_after_alloc} + {1'b0, free_cnt};
    free_ovf          = count_total > (DEPTH_BITS+2)'(DEPTH);
    wr_ptr_next       = wr_ptr + (free_ovf ? ptr_t'(0) : free_cnt);
    rd_ptr_next       = rd_ptr + taken;
    save_en           = ckpt_save && !flush && !ckpt_restore;
    if (flush)             rd_ptr_d = wr_ptr_next - ptr_t'(DEPTH);
    else if (ckpt_restore) rd_ptr_d = slot[ckpt_restore_id];
    else                   rd_ptr_d = rd_ptr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= ptr_t'(DEPTH);
      overflow_err <= 1'b0;
      // NOTE: the tag queue is reset on purpose: its contents are the initial free pool.
      for (int i = 0; i < DEPTH; i++) mem[i] <= PREG_BITS'(NUM_ARCH + i);
      for (int c = 0; c < NCKPT; c++) slot[c] <= '0;
    end else begin
      rd_ptr <= rd_ptr_d;
      wr_ptr <= wr_ptr_next;
      if (free_ovf) overflow_err <= 1'b1;
      if (!free_ovf) begin
        for (int j = 0; j < NFREE; j++) begin
          if (free_valid[j]) mem[free_idx[j][DEPTH_BITS-1:0]] <= free_preg[j];
        end
      end
      if (save_en) slot[ckpt_save_id] <= rd_ptr_next;
    end
  end

endmodule

// File: tb/tb_free_list_ckpt.sv
// Scoreboard bench for free_list_ckpt: expectations queued as stimulus is
// driven, compared against DUT outputs on the following falling edge.
module tb_free_list_ckpt;

  localparam int PB = 6;
  localparam int DB = 5;
  localparam int NA = 2;
  localparam int NF = 2;
  localparam int NC = 4;
  localparam int CB = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NA-1:0]         alloc_req;
  logic                  alloc_ready;
  logic [NA-1:0][PB-1:0] alloc_preg;
  logic [NF-1:0]         free_valid;
  logic [NF-1:0][PB-1:0] free_preg;
  logic                  ckpt_save;
  logic [CB-1:0]         ckpt_save_id;
  logic                  ckpt_restore;
  logic [CB-1:0]         ckpt_restore_id;
  logic                  flush;
  logic [DB:0]           free_count;
  logic                  overflow_err;

  free_list_ckpt #(
    .PREG_BITS(PB), .DEPTH_BITS(DB), .NUM_ARCH(32),
    .NALLOC(NA), .NFREE(NF), .NCKPT(NC)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
    .free_valid(free_valid), .free_preg(free_preg),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
    .flush(flush), .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef enum {S_PREG0, S_PREG1, S_READY, S_COUNT, S_OVF} sig_e;
  typedef struct {
    string tag;
    sig_e  sig;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int observe(input sig_e s);
    case (s)
      S_PREG0: return int'(alloc_preg[0]);
      S_PREG1: return int'(alloc_preg[1]);
      S_READY: return int'(alloc_ready);
      S_COUNT: return int'(free_count);
      default: return int'(overflow_err);
    endcase
  endfunction

  task automatic expect_val(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle, then advance one clock.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req       = '0;
    free_valid      = '0;
    free_preg       = '0;
    ckpt_save       = 1'b0;
    ckpt_save_id    = '0;
    ckpt_restore    = 1'b0;
    ckpt_restore_id = '0;
    flush           = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state
    expect_val("rst_count", S_COUNT, 32);
    expect_val("rst_ready", S_READY, 1);
    expect_val("rst_ovf",   S_OVF,   0);
    step();

    // Two-lane grant, then single lanes
    alloc_req = 2'b11;
    expect_val("a11_l0", S_PREG0, 32);
    expect_val("a11_l1", S_PREG1, 33);
    expect_val("a11_rdy", S_READY, 1);
    step();
    alloc_req = 2'b01;
    expect_val("a01_count", S_COUNT, 30);
    expect_val("a01_l0", S_PREG0, 34);
    step();
    alloc_req = 2'b10;
    expect_val("a10_count", S_COUNT, 29);
    expect_val("a10_l1", S_PREG1, 35);
    step();
    idle();
    expect_val("a10_adv", S_COUNT, 28);
    step();

    // Drain down to a single free tag
    alloc_req = 2'b11;
    for (int c = 0; c < 13; c++) begin
      expect_val("drain_l0", S_PREG0, 36 + 2*c);
      expect_val("drain_l1", S_PREG1, 37 + 2*c);
      step();
    end
    alloc_req = 2'b01;
    expect_val("drain_last", S_PREG0, 62);
    step();
    alloc_req     = 2'b11;
    free_valid    = 2'b01;
    free_preg[0]  = 6'd32;
    expect_val("stall_rdy", S_READY, 0);
    expect_val("stall_count", S_COUNT, 1);
    step();
    free_valid = '0;
    expect_val("refill_rdy", S_READY, 1);
    expect_val("refill_count", S_COUNT, 2);
    expect_val("refill_l0", S_PREG0, 63);
    expect_val("refill_l1", S_PREG1, 32);
    step();
    idle();
    expect_val("empty_count", S_COUNT, 0);
    expect_val("empty_rdy", S_READY, 0);
    step();

    // Checkpoint save / restore
    do_reset();
    alloc_req    = 2'b11;
    ckpt_save    = 1'b1;
    ckpt_save_id = 2'd2;
    expect_val("save_l0", S_PREG0, 32);
    expect_val("save_l1", S_PREG1, 33);
    step();
    ckpt_save = 1'b0;
    for (int c = 0; c < 2; c++) begin
      expect_val("spec_l0", S_PREG0, 34 + 2*c);
      expect_val("spec_l1", S_PREG1, 35 + 2*c);
      step();
    end
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2'd2;
    free_valid      = 2'b01;
    free_preg[0]    = 6'd50;
    expect_val("rest_rdy", S_READY, 0);
    expect_val("rest_count", S_COUNT, 26);
    step();
    idle();
    alloc_req = 2'b01;
    expect_val("post_rest_count", S_COUNT, 31);
    expect_val("post_rest_l0", S_PREG0, 34);
    expect_val("post_rest_rdy", S_READY, 1);
    step();

    // Full flush with same-cycle commits, then wrap-around allocation
    do_reset();
    alloc_req = 2'b11;
    for (int c = 0; c < 4; c++) begin
      expect_val("pre_fl_l0", S_PREG0, 32 + 2*c);
      expect_val("pre_fl_l1", S_PREG1, 33 + 2*c);
      step();
    end
    flush        = 1'b1;
    free_valid   = 2'b11;
    free_preg[0] = 6'd32;
    free_preg[1] = 6'd33;
    expect_val("flush_rdy", S_READY, 0);
    expect_val("flush_count", S_COUNT, 24);
    step();
    flush      = 1'b0;
    free_valid = '0;
    expect_val("post_fl_count", S_COUNT, 32);
    for (int c = 0; c < 16; c++) begin
      expect_val("wrap_l0", S_PREG0, 32 + ((2 + 2*c) % 32));
      expect_val("wrap_l1", S_PREG1, 32 + ((3 + 2*c) % 32));
      step();
    end
    idle();
    expect_val("wrap_count", S_COUNT, 0);
    expect_val("wrap_ovf", S_OVF, 0);
    step();

    // Overflow on a free into a full pool
    do_reset();
    free_valid   = 2'b01;
    free_preg[0] = 6'd40;
    expect_val("ovf_pre", S_OVF, 0);
    step();
    free_valid = '0;
    expect_val("ovf_set", S_OVF, 1);
    expect_val("ovf_count", S_COUNT, 32);
    step();
    alloc_req = 2'b11;
    expect_val("ovf_sticky", S_OVF, 1);
    expect_val("ovf_drop_l0", S_PREG0, 32);
    expect_val("ovf_drop_l1", S_PREG1, 33);
    step();
    do_reset();
    expect_val("ovf_clear", S_OVF, 0);
    expect_val("ovf_clr_count", S_COUNT, 32);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/free_list_ckpt.md
Name: free_list_ckpt

Overview:
- Multi-lane physical-register free list for the OoO core: a circular queue of free preg tags with NALLOC rename-side allocate lanes and NFREE commit-side release lanes.
- Adds per-branch checkpoint save/restore of the allocation pointer for fast mispredict recovery.
- Keeps the full-flush recovery that returns every uncommitted allocation to the free pool.
- Sits between rename (alloc) and ROB commit (free).

Parameters:
PREG_BITS, 6, width of a physical register tag
DEPTH_BITS, 5, log2 of queue depth; DEPTH = 2**DEPTH_BITS = number of non-architectural pregs
NUM_ARCH, 32, first free tag at reset (entry i resets to NUM_ARCH+i)
NALLOC, 2, allocate lanes per cycle
NFREE, 2, release lanes per cycle
NCKPT, 4, number of checkpoint slots; CKPT_BITS = $clog2(NCKPT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_req  in  NALLOC  per-lane allocate request
alloc_ready  out  1  all NALLOC lanes can be served this cycle
alloc_preg  out  PREG_BITS x NALLOC  tag granted to each requesting lane
free_valid  in  NFREE  per-lane release
free_preg  in  PREG_BITS x NFREE  tag released per lane
ckpt_save  in  1  snapshot allocation pointer
ckpt_save_id  in  CKPT_BITS  slot to write
ckpt_restore  in  1  restore allocation pointer from slot
ckpt_restore_id  in  CKPT_BITS  slot to read
flush  in  1  full pipeline flush (rob_flush)
free_count  out  DEPTH_BITS+1  number of free tags currently held
overflow_err  out  1  sticky protocol error

Behaviour:
- Storage: mem[DEPTH] of PREG_BITS. Pointers rd_ptr and wr_ptr are DEPTH_BITS+1 bits, where the MSB is the wrap bit. free_count = wr_ptr - rd_ptr (mod 2**(DEPTH_BITS+1)), range 0..DEPTH.
- Reset:
  - mem[i] = NUM_ARCH+i.
  - rd_ptr = 0; wr_ptr = DEPTH.
  - free_count = DEPTH, alloc_ready = 1, overflow_err = 0.
  - All checkpoint slots = 0.
- Alloc (combinational outputs):
  - alloc_ready = (free_count >= NALLOC) and not flush and not ckpt_restore.
  - Lane k with alloc_req[k]=1 gets alloc_preg[k] = mem[(rd_ptr + popcount(alloc_req[k-1:0])) mod DEPTH].
  - Lanes with alloc_req[k]=0 output 'x.
  - A grant takes effect only when alloc_ready=1; rd_ptr then advances by popcount(alloc_req) at the clock edge.
  - With alloc_ready=0 nothing is consumed and rename stalls. Grants are all-or-nothing; there are no partial grants.
- Free:
  - Lane j with free_valid[j]=1 writes free_preg[j] to mem[(wr_ptr + popcount(free_valid[j-1:0])) mod DEPTH].
  - wr_ptr advances by popcount(free_valid).
  - Frees are applied in every non-reset cycle, including flush and restore cycles.
  - If free_count_after_alloc + popcount(free_valid) > DEPTH: overflow_err <= 1 (sticky until rst), and that cycle's frees are dropped.
- Same-cycle alloc and free: the alloc sees the pre-edge state only. A tag freed this cycle is not grantable until the next cycle, so there is no bypass.
- Checkpoint save:
  - When ckpt_save=1 with no flush and no restore, slot[ckpt_save_id] <= rd_ptr_next, i.e. rd_ptr after this cycle's allocations.
  - A save is ignored in flush and restore cycles.
- Checkpoint restore: rd_ptr <= slot[ckpt_restore_id]. Allocs are suppressed that cycle. wr_ptr still updates with that cycle's frees.
- Flush: rd_ptr <= wr_ptr_next - DEPTH, so free_count = DEPTH next cycle and all uncommitted tags are returned.
- Precondition for flush and restore correctness: exactly one free per committed allocation. Slots in [rd_commit, rd_ptr) are then never overwritten.
- Priority: rst > flush > ckpt_restore > normal alloc/save.
- Pointer arithmetic wraps modulo 2**(DEPTH_BITS+1). Memory index = low DEPTH_BITS bits.

Test Plan:
- Reset, then alloc_req=2'b11 for 1 cycle -> alloc_preg = {33,32}. Next cycle free_count=30 and alloc_preg[0]=34.
- Lanes with alloc_req=2'b10 -> lane1 gets 32 and lane0 is 'x. rd_ptr +1.
- Drain to free_count=1, then alloc_req=2'b11 -> alloc_ready=0 and free_count stays 1. Then free_valid=2'b01, free_preg=32 -> next cycle free_count=2 and alloc_ready=1.
- Save slot 2 after allocating 32,33; allocate 34..37; restore slot 2 -> free_count=30 and next alloc_preg[0]=34. A free of 50 in the restore cycle -> free_count=31.
- Allocate 32..39 with no commits, then flush in the same cycle as free_valid=2'b11 -> next cycle free_count=32. Continuing allocation wraps past index 31 without error.
- Reset state (free_count=32), free_valid=2'b01 -> overflow_err=1 and stays 1; free_count stays 32. A later rst clears overflow_err.
